// File: rtl/router_pkt_pkg.sv
// Shared types and constants for the router packet transmitter.
// Header layout is {len, addr}; parity is the XOR of header and payload.
package router_pkt_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W = 6;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;
  localparam int MAX_LEN = 63;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } state_t;

  function automatic logic [7:0] hdr_pack(
    input logic [LEN_W-1:0]  len,
    input logic [ADDR_W-1:0] addr
  );
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_txbuf.sv
// First-word-fall-through byte FIFO holding payload ahead of transmission.
// Pushes into a full FIFO and pops from an empty one are ignored.
module router_pkt_txbuf #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic [7:0]    head
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // storage array, no reset needed
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop)  rptr <= nxt(rptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter: header, buffered payload, then XOR parity byte.
// The full packet is buffered before the header so valid never drops.
import router_pkt_pkg::*;

module router_pkt_tx #(
  parameter int GAP_CYCLES = 2,
  parameter int BUF_DEPTH  = 64
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_addr,
  input  logic [5:0]  req_len,
  input  logic        pay_valid,
  output logic        pay_ready,
  input  logic [7:0]  pay_data,
  input  logic        busy,
  input  logic        error,
  output logic [7:0]  tx_data,
  output logic        tx_pkt_valid,
  output logic        pkt_done,
  output logic [7:0]  drop_cnt,
  output logic [7:0]  err_cnt
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  byte_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [7:0]        parity;
  logic              err_q;

  logic [CW-1:0]     buf_count;
  logic              buf_full;
  logic              buf_empty;
  logic [7:0]        buf_head;
  logic              pop;
  logic              data_ok;
  logic              last;
  logic              bad_req;

  assign req_ready = (state == IDLE);
  assign pay_ready = !buf_full;
  assign data_ok   = (buf_count >= CW'(len_q));
  assign last      = (byte_cnt == len_q - 1'b1);
  assign bad_req   = (req_addr == ADDR_INVALID) ||
                     (req_len == '0);

  // tx_data is registered, so each byte is popped as it is loaded
  assign pop = !busy && !buf_empty &&
               ((state == HEADER) ||
                (state == PAYLOAD && !last));

  router_pkt_txbuf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clock  (clock),
    .resetn (resetn),
    .push   (pay_valid),
    .wdata  (pay_data),
    .pop    (pop),
    .count  (buf_count),
    .full   (buf_full),
    .empty  (buf_empty),
    .head   (buf_head)
  );

  // packet sequencing with registered wire outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      byte_cnt     <= '0;
      gap_cnt      <= '0;
      parity       <= '0;
      tx_data      <= '0;
      tx_pkt_valid <= 1'b0;
      pkt_done     <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      pkt_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            if (bad_req) begin
              if (drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 1'b1;
            end else begin
              addr_q <= req_addr;
              len_q  <= req_len;
              state  <= WAIT_DATA;
            end
          end
        end
        WAIT_DATA: begin
          if (data_ok) begin
            state        <= HEADER;
            tx_data      <= hdr_pack(len_q, addr_q);
            parity       <= hdr_pack(len_q, addr_q);
            tx_pkt_valid <= 1'b1;
          end
        end
        HEADER: begin
          if (!busy) begin
            state    <= PAYLOAD;
            tx_data  <= buf_head;
            byte_cnt <= '0;
          end
        end
        PAYLOAD: begin
          if (!busy) begin
            parity   <= parity ^ tx_data;
            byte_cnt <= byte_cnt + 1'b1;
            if (last) begin
              state        <= PARITY;
              tx_data      <= parity ^ tx_data;
              tx_pkt_valid <= 1'b0;
            end else begin
              tx_data <= buf_head;
            end
          end
        end
        PARITY: begin
          if (!busy) begin
            state    <= GAP;
            tx_data  <= '0;
            pkt_done <= 1'b1;
            gap_cnt  <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1))
            state <= IDLE;
          else
            gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // count rising edges of the router error flag
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err_q   <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_q <= error;
      if (error && !err_q && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: cycle table, scoreboard
// of consumed wire bytes, and hand sequences for stalls and reset.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_addr = '0;
  logic [5:0] req_len = '0;
  logic       pay_valid = 1'b0;
  logic [7:0] pay_data = '0;
  logic       busy_force = 1'b0;
  logic       busy_rand = 1'b0;
  logic       busy_r = 1'b0;
  logic       busy;
  logic       error = 1'b0;
  logic       req_ready;
  logic       pay_ready;
  logic [7:0] tx_data;
  logic       tx_pkt_valid;
  logic       pkt_done;
  logic [7:0] drop_cnt;
  logic [7:0] err_cnt;

  int checks = 0;
  int failures = 0;
  int ndone = 0;
  logic in_pkt = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       valid;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       done;
    logic       ready;
  } cyc_t;
  cyc_t tbl[9];

  typedef struct {
    logic [1:0] a;
    logic [5:0] l;
    logic [7:0] first;
    logic [7:0] step;
    logic       rnd;
  } pkt_t;
  pkt_t pkts[4];

  assign busy = busy_force | busy_r;

  router_pkt_tx #(
    .GAP_CYCLES (2),
    .BUF_DEPTH  (64)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .pay_valid    (pay_valid),
    .pay_ready    (pay_ready),
    .pay_data     (pay_data),
    .busy         (busy),
    .error        (error),
    .tx_data      (tx_data),
    .tx_pkt_valid (tx_pkt_valid),
    .pkt_done     (pkt_done),
    .drop_cnt     (drop_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    busy_r <= busy_rand && ($urandom_range(0, 2) == 0);
  end

  task automatic fail(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
    failures++;
    $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) fail(name, act, exp);
  endtask

  // scoreboard: every byte the router consumes, including parity
  always @(negedge clock) begin
    exp_t e;
    if (!resetn) begin
      in_pkt <= 1'b0;
    end else begin
      if (pkt_done) ndone <= ndone + 1;
      if (!busy && (tx_pkt_valid || in_pkt)) begin
        if (sb.size() == 0) begin
          checks++;
          fail("sb_extra", {23'd0, tx_pkt_valid, tx_data}, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_data", tx_data, e.data);
          chk("sb_valid", tx_pkt_valid, e.valid);
        end
        in_pkt <= tx_pkt_valid;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_bytes(input logic [7:0] first,
                            input logic [7:0] step,
                            input int n);
    logic [7:0] b;
    int w;
    b = first;
    for (int i = 0; i < n; i++) begin
      pay_valid = 1'b1;
      pay_data = b;
      w = 0;
      while (!pay_ready && w < 500) begin
        tick();
        w++;
      end
      tick();
      b = b + step;
    end
    pay_valid = 1'b0;
  endtask

  task automatic expect_pkt(input logic [1:0] a,
                            input logic [5:0] l,
                            input logic [7:0] first,
                            input logic [7:0] step);
    logic [7:0] b;
    logic [7:0] p;
    exp_t e;
    p = {l, a};
    e.data = p;
    e.valid = 1'b1;
    sb.push_back(e);
    b = first;
    for (int i = 0; i < int'(l); i++) begin
      e.data = b;
      sb.push_back(e);
      p = p ^ b;
      b = b + step;
    end
    e.data = p;
    e.valid = 1'b0;
    sb.push_back(e);
  endtask

  task automatic send_req(input logic [1:0] a,
                          input logic [5:0] l);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_addr = a;
    req_len = l;
    while (!req_ready && n < 2000) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      checks++;
      fail("req_timeout", n, 0);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_timeout", n < 3000, 1);
  endtask

  initial begin
    int n;
    int nd;
    logic early;

    tbl[0] = '{8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h0D, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'hA1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'hB2, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'hC3, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'hDD, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{8'h00, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{8'h00, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{8'h00, 1'b0, 1'b0, 1'b1};

    pkts[0] = '{2'd0, 6'd1,  8'h5A, 8'h00, 1'b0};
    pkts[1] = '{2'd2, 6'd2,  8'hFF, 8'h01, 1'b1};
    pkts[2] = '{2'd1, 6'd7,  8'h00, 8'h03, 1'b1};
    pkts[3] = '{2'd0, 6'd20, 8'h80, 8'h07, 1'b1};

    // reset state
    #2 resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_valid", tx_pkt_valid, 1'b0);
    chk("rst_pkt_done", pkt_done, 1'b0);
    chk("rst_drop_cnt", drop_cnt, 8'h00);
    chk("rst_err_cnt", err_cnt, 8'h00);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_pay_ready", pay_ready, 1'b1);
    resetn = 1'b1;
    tick();

    // basic packet, cycle-exact against the table
    push_bytes(8'hA1, 8'h11, 3);
    expect_pkt(2'd1, 6'd3, 8'hA1, 8'h11);
    nd = ndone;
    send_req(2'd1, 6'd3);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      chk($sformatf("t1_data_%0d", i), tx_data, tbl[i].data);
      chk($sformatf("t1_valid_%0d", i), tx_pkt_valid, tbl[i].valid);
      chk($sformatf("t1_done_%0d", i), pkt_done, tbl[i].done);
      chk($sformatf("t1_ready_%0d", i), req_ready, tbl[i].ready);
    end
    drain();
    chk("t1_ndone", ndone, nd + 1);

    // busy stall while B2 is on the wire
    push_bytes(8'hA1, 8'h11, 3);
    expect_pkt(2'd1, 6'd3, 8'hA1, 8'h11);
    nd = ndone;
    send_req(2'd1, 6'd3);
    n = 0;
    while (!(tx_pkt_valid && tx_data == 8'hB2) && n < 50) begin
      tick();
      n++;
    end
    chk("t2_found_b2", n < 50, 1);
    busy_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_data", tx_data, 8'hB2);
      chk("t2_hold_valid", tx_pkt_valid, 1'b1);
    end
    busy_force = 1'b0;
    drain();
    chk("t2_ndone", ndone, nd + 1);

    // invalid requests are dropped, buffered payload survives
    push_bytes(8'h10, 8'h01, 5);
    send_req(2'd3, 6'd5);
    chk("t3_drop1", drop_cnt, 8'd1);
    chk("t3_idle1", req_ready, 1'b1);
    send_req(2'd0, 6'd0);
    chk("t3_drop2", drop_cnt, 8'd2);
    chk("t3_idle2", req_ready, 1'b1);
    repeat (4) tick();
    chk("t3_no_tx", tx_pkt_valid, 1'b0);
    expect_pkt(2'd2, 6'd5, 8'h10, 8'h01);
    send_req(2'd2, 6'd5);
    drain();

    // table of packets, some under random busy
    foreach (pkts[k]) begin
      push_bytes(pkts[k].first, pkts[k].step, int'(pkts[k].l));
      expect_pkt(pkts[k].a, pkts[k].l, pkts[k].first, pkts[k].step);
      nd = ndone;
      busy_rand = pkts[k].rnd;
      send_req(pkts[k].a, pkts[k].l);
      drain();
      busy_rand = 1'b0;
      chk($sformatf("tbl_ndone_%0d", k), ndone, nd + 1);
    end

    // max length with slow payload: header waits for byte 63
    expect_pkt(2'd0, 6'd63, 8'h01, 8'h01);
    send_req(2'd0, 6'd63);
    early = 1'b0;
    for (int i = 0; i < 63; i++) begin
      pay_valid = 1'b1;
      pay_data = 8'(i + 1);
      tick();
      pay_valid = 1'b0;
      if (i < 62 && tx_pkt_valid) early = 1'b1;
      tick();
      if (i < 62 && tx_pkt_valid) early = 1'b1;
    end
    chk("t4_no_early_hdr", early, 1'b0);
    n = 0;
    while (!tx_pkt_valid && n < 20) begin
      tick();
      n++;
    end
    n = 0;
    while (tx_pkt_valid && n < 200) begin
      n++;
      tick();
    end
    chk("t4_valid_run", n, 64);
    drain();

    // reset during payload
    push_bytes(8'h55, 8'h01, 3);
    expect_pkt(2'd1, 6'd3, 8'h55, 8'h01);
    send_req(2'd1, 6'd3);
    n = 0;
    while (!(tx_pkt_valid && tx_data == 8'h55) && n < 50) begin
      tick();
      n++;
    end
    chk("t5_in_payload", n < 50, 1);
    #2 resetn = 1'b0;
    sb.delete();
    #1;
    chk("t5_rst_valid", tx_pkt_valid, 1'b0);
    chk("t5_rst_data", tx_data, 8'h00);
    tick();
    resetn = 1'b1;
    tick();
    chk("t5_req_ready", req_ready, 1'b1);
    chk("t5_pay_ready", pay_ready, 1'b1);
    chk("t5_drop_clr", drop_cnt, 8'h00);
    send_req(2'd1, 6'd1);
    repeat (5) tick();
    chk("t5_buf_flushed", tx_pkt_valid, 1'b0);
    expect_pkt(2'd1, 6'd1, 8'h9A, 8'h00);
    push_bytes(8'h9A, 8'h00, 1);
    drain();

    // error edge counting and saturation
    for (int i = 0; i < 2; i++) begin
      error = 1'b1;
      tick();
      error = 1'b0;
      tick();
    end
    tick();
    chk("t6_err2", err_cnt, 8'd2);
    for (int i = 0; i < 600; i++) begin
      error = ~error;
      tick();
    end
    error = 1'b0;
    tick();
    chk("t6_err_sat", err_cnt, 8'd255);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
